// File: rtl/debounced_comparator.sv
// rtl/debounced_comparator.sv - mode-selectable comparator with symmetric debounce and match event counter
//
// Purpose:
//   Compares two unsigned WIDTH-bit operands as EQ/NE/GT/LT and filters the
//   result so that match only flips after DEBOUNCE consecutive valid samples
//   disagree with it. Rising edges of match are strobed and counted.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   in_valid     in   a, b, mode sampled this cycle
//   a, b         in   WIDTH-bit unsigned operands
//   mode         in   00 EQ, 01 NE, 10 GT (a>b), 11 LT (a<b)
//   clr_count    in   synchronous clear of match_count
//   raw          out  registered unfiltered result of the last valid sample
//   out_valid    out  in_valid delayed one cycle
//   match        out  debounced result
//   match_pulse  out  one-cycle strobe on each 0->1 of match
//   match_count  out  saturating count of 0->1 transitions of match

module debounced_comparator #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             clr_count,
    output logic             raw,
    output logic             out_valid,
    output logic             match,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned RUN_W = $clog2(DEBOUNCE + 1);

    // run never exceeds DEBOUNCE-1, so reaching this value with one more
    // disagreeing sample means the run is complete.
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] MODE_EQ = 2'b00;
    localparam logic [1:0] MODE_NE = 2'b01;
    localparam logic [1:0] MODE_GT = 2'b10;

    logic             cond;
    logic             flip;
    logic             rise;
    logic [RUN_W-1:0] run;

    always_comb begin
        cond = 1'b0;
        case (mode)
            MODE_EQ: cond = (a == b);
            MODE_NE: cond = (a != b);
            MODE_GT: cond = (a > b);
            default: cond = (a < b);
        endcase
    end

    // flip: this valid sample completes a disagreeing run.
    // rise: that flip takes match from 0 to 1.
    assign flip = in_valid && (cond != match) && (run == RUN_LAST);
    assign rise = flip && cond;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw         <= 1'b0;
            out_valid   <= 1'b0;
            match       <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= '0;
            run         <= '0;
        end else begin
            out_valid   <= in_valid;
            match_pulse <= rise;

            // Invalid cycles leave raw, run and match untouched, so gaps
            // neither extend nor break a run.
            if (in_valid) begin
                raw <= cond;
                if (cond == match) begin
                    run <= '0;
                end else if (flip) begin
                    match <= cond;
                    run   <= '0;
                end else begin
                    run <= run + RUN_W'(1);
                end
            end

            // Clear wins over a coincident increment; the pulse still fires.
            if (clr_count) begin
                match_count <= '0;
            end else if (rise && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_debounced_comparator.sv
// tb/tb_debounced_comparator.sv - scoreboard bench for debounced_comparator

module tb_debounced_comparator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut0: WIDTH=4, DEBOUNCE=3, CNT_W=8
    logic       v0, clr0;
    logic [3:0] a0, b0;
    logic [1:0] md0;
    logic       raw0, ov0, m0, p0;
    logic [7:0] cnt0;

    // dut1: WIDTH=4, DEBOUNCE=1, CNT_W=2
    logic       v1, clr1;
    logic [3:0] a1, b1;
    logic [1:0] md1;
    logic       raw1, ov1, m1, p1;
    logic [1:0] cnt1;

    debounced_comparator #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .a(a0), .b(b0), .mode(md0),
        .clr_count(clr0), .raw(raw0), .out_valid(ov0), .match(m0),
        .match_pulse(p0), .match_count(cnt0)
    );

    debounced_comparator #(.WIDTH(4), .DEBOUNCE(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .mode(md1),
        .clr_count(clr1), .raw(raw1), .out_valid(ov1), .match(m1),
        .match_pulse(p1), .match_count(cnt1)
    );

    typedef struct packed {
        logic       raw;
        logic       match;
        logic       pulse;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] EQ = 2'b00, NE = 2'b01, GT = 2'b10, LT = 2'b11;

    // Drive one cycle on dut0 (and hold dut1 idle); outputs are sampled 1ns after the edge.
    task automatic step0(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] md, input logic clr);
        v0 = v; a0 = a; b0 = b; md0 = md; clr0 = clr;
        v1 = 1'b0; clr1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] md);
        v1 = v; a1 = a; b1 = b; md1 = md; clr1 = 1'b0;
        v0 = 1'b0; clr0 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got;
        rst = 1'b1;
        step0(1'b1, 4'hA, 4'hA, EQ, 1'b0);
        v1 = 1'b1; a1 = 4'h3; b1 = 4'h3; md1 = EQ;
        @(posedge clk);
        #1;
        total++;
        got = {raw0, m0, p0, cnt0};
        if (got !== '0 || ov0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_dut0: got raw=%b match=%b pulse=%b cnt=%0d ov=%b want all 0",
                     raw0, m0, p0, cnt0, ov0);
        end
        total++;
        if ({raw1, m1, p1, cnt1, ov1} !== 6'b0) begin
            bad++;
            $display("FAIL reset_dut1: got raw=%b match=%b pulse=%b cnt=%0d ov=%b want all 0",
                     raw1, m1, p1, cnt1, ov1);
        end
        rst = 1'b0;
        step0(1'b0, 4'h0, 4'h0, EQ, 1'b0);
        total++;
        got = {raw0, m0, p0, cnt0};
        if (got !== '0 || ov0 !== 1'b0 || ov1 !== 1'b0 || cnt1 !== 2'd0) begin
            bad++;
            $display("FAIL reset_release: got raw=%b match=%b pulse=%b cnt=%0d ov=%b ov1=%b cnt1=%0d want all 0",
                     raw0, m0, p0, cnt0, ov0, ov1, cnt1);
        end
    endtask

    // Each row: valid, a, b, mode, clr, expected raw/match/pulse/count.
    typedef struct packed {
        logic       v;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] md;
        logic       clr;
        exp_t       e;
    } row_t;

    task automatic run_rows0(input string name, input row_t rows[$]);
        exp_t got, want;
        foreach (rows[i]) begin
            if (rows[i].v) sb0.push_back(rows[i].e);
            step0(rows[i].v, rows[i].a, rows[i].b, rows[i].md, rows[i].clr);
            if (rows[i].v) begin
                total++;
                if (ov0 !== 1'b1 || sb0.size() == 0) begin
                    bad++;
                    $display("FAIL %s_ov[%0d]: got out_valid=%b want 1", name, i, ov0);
                    sb0.delete();
                end else begin
                    got  = {raw0, m0, p0, cnt0};
                    want = sb0.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL %s[%0d]: got raw=%b match=%b pulse=%b cnt=%0d want raw=%b match=%b pulse=%b cnt=%0d",
                                 name, i, got.raw, got.match, got.pulse, got.cnt,
                                 want.raw, want.match, want.pulse, want.cnt);
                    end
                end
            end else begin
                total++;
                got = {raw0, m0, p0, cnt0};
                if (ov0 !== 1'b0 || got !== rows[i].e) begin
                    bad++;
                    $display("FAIL %s_idle[%0d]: got ov=%b raw=%b match=%b pulse=%b cnt=%0d want ov=0 raw=%b match=%b pulse=%b cnt=%0d",
                             name, i, ov0, got.raw, got.match, got.pulse, got.cnt,
                             rows[i].e.raw, rows[i].e.match, rows[i].e.pulse, rows[i].e.cnt);
                end
            end
        end
    endtask

    function automatic row_t r(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic [1:0] md, input logic clr,
                               input logic er, input logic em, input logic ep, input logic [7:0] ec);
        row_t x;
        x.v = v; x.a = a; x.b = b; x.md = md; x.clr = clr;
        x.e = '{raw: er, match: em, pulse: ep, cnt: ec};
        return x;
    endfunction

    task automatic test_eq_run();
        row_t rows[$];
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 1, 1, 8'd1));
        rows.push_back(r(0, 4'h0, 4'h0, EQ, 0, 1, 1, 0, 8'd1));
        run_rows0("eq_run", rows);
    endtask

    task automatic test_broken_run();
        row_t rows[$];
        rst = 1'b1;
        step0(1'b0, 4'h0, 4'h0, EQ, 1'b0);
        rst = 1'b0;
        sb0.delete();
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'hC, 4'hA, EQ, 0, 0, 0, 0, 8'd0));
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 1, 1, 8'd1));
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 1, 0, 8'd1));
        rows.push_back(r(1, 4'hA, 4'hA, EQ, 0, 1, 1, 0, 8'd1));
        run_rows0("broken_run", rows);
    endtask

    task automatic test_gap_fall();
        row_t rows[$];
        rows.push_back(r(1, 4'h5, 4'h5, LT, 0, 0, 1, 0, 8'd1));
        rows.push_back(r(1, 4'h5, 4'h5, LT, 0, 0, 1, 0, 8'd1));
        for (int i = 0; i < 4; i++)
            rows.push_back(r(0, 4'h5, 4'h5, LT, 0, 0, 1, 0, 8'd1));
        rows.push_back(r(1, 4'h5, 4'h5, LT, 0, 0, 0, 0, 8'd1));
        rows.push_back(r(0, 4'h5, 4'h5, LT, 0, 0, 0, 0, 8'd1));
        run_rows0("gap_fall", rows);
    endtask

    // DEBOUNCE=1: match follows each valid cond; count saturates at 3.
    task automatic test_saturate();
        exp_t  got, want;
        logic  c;
        logic [7:0] ec;
        for (int i = 0; i < 10; i++) begin
            c  = (i % 2 == 0);
            ec = (i / 2 + 1 > 3) ? 8'd3 : 8'(i / 2 + 1);
            sb1.push_back('{raw: c, match: c, pulse: c, cnt: ec});
            step1(1'b1, 4'h6, c ? 4'h6 : 4'h2, EQ);
            total++;
            if (ov1 !== 1'b1 || sb1.size() == 0) begin
                bad++;
                $display("FAIL saturate_ov[%0d]: got out_valid=%b want 1", i, ov1);
                sb1.delete();
            end else begin
                got  = {raw1, m1, p1, 6'b0, cnt1};
                want = sb1.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL saturate[%0d]: got raw=%b match=%b pulse=%b cnt=%0d want raw=%b match=%b pulse=%b cnt=%0d",
                             i, got.raw, got.match, got.pulse, got.cnt,
                             want.raw, want.match, want.pulse, want.cnt);
                end
            end
        end
    endtask

    // Mode decoding and unsigned ordering, observed through DEBOUNCE=1.
    task automatic test_modes();
        exp_t got, want;
        logic [3:0] ta[8] = '{4'hF, 4'h0, 4'h0, 4'h7, 4'h3, 4'h9, 4'h0, 4'h8};
        logic [3:0] tb[8] = '{4'h0, 4'hF, 4'hF, 4'h7, 4'h4, 4'h9, 4'h0, 4'h7};
        logic [1:0] tm[8] = '{GT,   GT,   LT,   LT,   NE,   NE,   EQ,   GT};
        logic       tc[8] = '{1,    0,    1,    0,    1,    0,    1,    1};
        logic       tp[8] = '{1,    0,    1,    0,    1,    0,    1,    0};
        for (int i = 0; i < 8; i++) begin
            sb1.push_back('{raw: tc[i], match: tc[i], pulse: tp[i], cnt: 8'd3});
            step1(1'b1, ta[i], tb[i], tm[i]);
            total++;
            if (ov1 !== 1'b1 || sb1.size() == 0) begin
                bad++;
                $display("FAIL modes_ov[%0d]: got out_valid=%b want 1", i, ov1);
                sb1.delete();
            end else begin
                got  = {raw1, m1, p1, 6'b0, cnt1};
                want = sb1.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL modes[%0d]: got raw=%b match=%b pulse=%b cnt=%0d want raw=%b match=%b pulse=%b cnt=%0d",
                             i, got.raw, got.match, got.pulse, got.cnt,
                             want.raw, want.match, want.pulse, want.cnt);
                end
            end
        end
    endtask

    task automatic test_clear_and_midrun_reset();
        row_t rows[$];
        exp_t got;
        rows.push_back(r(1, 4'h2, 4'h2, EQ, 0, 1, 0, 0, 8'd1));
        rows.push_back(r(1, 4'h2, 4'h2, EQ, 0, 1, 0, 0, 8'd1));
        rows.push_back(r(1, 4'h2, 4'h2, EQ, 1, 1, 1, 1, 8'd0));
        rows.push_back(r(0, 4'h2, 4'h2, EQ, 0, 1, 1, 0, 8'd0));
        rows.push_back(r(1, 4'h2, 4'h3, EQ, 0, 0, 1, 0, 8'd0));
        rows.push_back(r(1, 4'h2, 4'h3, EQ, 0, 0, 1, 0, 8'd0));
        rows.push_back(r(1, 4'h2, 4'h3, EQ, 0, 0, 0, 0, 8'd0));
        rows.push_back(r(1, 4'h4, 4'h4, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'h4, 4'h4, EQ, 0, 1, 0, 0, 8'd0));
        run_rows0("clear", rows);

        rst = 1'b1;
        step0(1'b0, 4'h0, 4'h0, EQ, 1'b0);
        rst = 1'b0;
        sb0.delete();
        total++;
        got = {raw0, m0, p0, cnt0};
        if (got !== '0 || ov0 !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: got raw=%b match=%b pulse=%b cnt=%0d ov=%b want all 0",
                     raw0, m0, p0, cnt0, ov0);
        end

        rows.delete();
        rows.push_back(r(1, 4'h4, 4'h4, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'h4, 4'h4, EQ, 0, 1, 0, 0, 8'd0));
        rows.push_back(r(1, 4'h4, 4'h4, EQ, 0, 1, 1, 1, 8'd1));
        run_rows0("after_reset", rows);
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; a0 = '0; b0 = '0; md0 = EQ; clr0 = 1'b0;
        v1 = 1'b0; a1 = '0; b1 = '0; md1 = EQ; clr1 = 1'b0;
        test_reset();
        test_eq_run();
        test_broken_run();
        test_gap_fall();
        test_saturate();
        test_modes();
        test_clear_and_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
